// File: rtl/frog_mover.sv
// Frog position controller: debounced buttons become grid hops applied at frame start.
// Handles screen bounds, goal row and death freeze/respawn; all outputs registered.
module frog_mover #(
   parameter int GRID_SIZE       = 32,
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480,
   parameter int START_X         = 320,
   parameter int START_Y         = 448,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DEATH_FRAMES    = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       frame_start,
   input  logic       collision,
   output logic [9:0] frog_x,
   output logic [9:0] frog_y,
   output logic       frog_dead,
   output logic       hop,
   output logic       level_win
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DW = $clog2(DEATH_FRAMES + 1);

   typedef enum logic [2:0] {IDLE, PENDING, HOLD, WIN, DEAD} state_t;

   logic [3:0]    raw, sync1, sync2, deb, deb_q, press;
   logic [CW-1:0] cnt [4];

   state_t        state, state_nxt;
   logic [1:0]    dir, dir_nxt;
   logic [9:0]    x_nxt, y_nxt;
   logic          dead_nxt, hop_nxt, win_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;
   logic [10:0]   mv_x, mv_y;
   logic          legal, collide;

   assign raw     = {btn_up, btn_down, btn_left, btn_right};
   assign press   = deb & ~deb_q;
   assign collide = frame_start & collision;

   // Counter runs only while the synced input disagrees with the debounced level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] != deb[i]) begin
               if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                  deb[i] <= sync2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // 11-bit arithmetic: an underflow wraps far above any legal bound
   always_comb begin
      mv_x = {1'b0, frog_x};
      mv_y = {1'b0, frog_y};
      case (dir)
         2'd0:    mv_y = {1'b0, frog_y} - 11'(GRID_SIZE);
         2'd1:    mv_y = {1'b0, frog_y} + 11'(GRID_SIZE);
         2'd2:    mv_x = {1'b0, frog_x} - 11'(GRID_SIZE);
         default: mv_x = {1'b0, frog_x} + 11'(GRID_SIZE);
      endcase
      legal = (mv_x <= 11'(H_ACTIVE - GRID_SIZE)) && (mv_y <= 11'(V_ACTIVE - GRID_SIZE));
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      x_nxt     = frog_x;
      y_nxt     = frog_y;
      dead_nxt  = frog_dead;
      hop_nxt   = 1'b0;
      win_nxt   = 1'b0;
      dcnt_nxt  = dcnt;
      case (state)
         IDLE: begin
            if (collide) begin
               state_nxt = DEAD;
               dead_nxt  = 1'b1;
               dcnt_nxt  = '0;
            end else if (|press) begin
               state_nxt = PENDING;
               dir_nxt   = press[3] ? 2'd0 : press[2] ? 2'd1 : press[1] ? 2'd2 : 2'd3;
            end
         end
         PENDING: begin
            if (collide) begin
               state_nxt = DEAD;
               dead_nxt  = 1'b1;
               dcnt_nxt  = '0;
            end else if (frame_start) begin
               state_nxt = HOLD;
               if (legal) begin
                  x_nxt   = mv_x[9:0];
                  y_nxt   = mv_y[9:0];
                  hop_nxt = 1'b1;
                  if (mv_y == 11'd0) begin
                     state_nxt = WIN;
                     win_nxt   = 1'b1;
                  end
               end
            end
         end
         HOLD: begin
            if (collide) begin
               state_nxt = DEAD;
               dead_nxt  = 1'b1;
               dcnt_nxt  = '0;
            end else if (deb == 4'b0000) begin
               state_nxt = IDLE;
            end
         end
         WIN: begin
            if (frame_start) begin
               x_nxt     = 10'(START_X);
               y_nxt     = 10'(START_Y);
               state_nxt = HOLD;
            end
         end
         DEAD: begin
            if (frame_start) begin
               if (dcnt == DW'(DEATH_FRAMES - 1)) begin
                  x_nxt     = 10'(START_X);
                  y_nxt     = 10'(START_Y);
                  dead_nxt  = 1'b0;
                  dcnt_nxt  = '0;
                  state_nxt = HOLD;
               end else begin
                  dcnt_nxt = dcnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dir       <= 2'd0;
         frog_x    <= 10'(START_X);
         frog_y    <= 10'(START_Y);
         frog_dead <= 1'b0;
         hop       <= 1'b0;
         level_win <= 1'b0;
         dcnt      <= '0;
      end else begin
         state     <= state_nxt;
         dir       <= dir_nxt;
         frog_x    <= x_nxt;
         frog_y    <= y_nxt;
         frog_dead <= dead_nxt;
         hop       <= hop_nxt;
         level_win <= win_nxt;
         dcnt      <= dcnt_nxt;
      end
   end

endmodule

// File: tb/tb_frog_mover.sv
// Scoreboarded bench for frog_mover: expected hops queued by a grid model, checked by a monitor.
module tb_frog_mover;

   localparam int GRID = 32;
   localparam int SX   = 320;
   localparam int SY   = 448;
   localparam int MAXX = 608;
   localparam int MAXY = 448;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       frame_start = 1'b0, collision = 1'b0;
   logic [9:0] frog_x, frog_y;
   logic       frog_dead, hop, level_win;

   int errors = 0;
   int checks = 0;
   int mx = SX;
   int my = SY;

   typedef struct {int x; int y; bit win;} exp_t;
   exp_t exp_q[$];

   frog_mover #(
      .DEBOUNCE_CYCLES(4),
      .DEATH_FRAMES(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .frame_start(frame_start), .collision(collision),
      .frog_x(frog_x), .frog_y(frog_y),
      .frog_dead(frog_dead), .hop(hop), .level_win(level_win)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every hop pulse must match the oldest expected move
   always @(negedge clk) begin
      if (rst_n) begin
         if (hop) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_hop: got hop at x=%0d y=%0d, expected none", frog_x, frog_y);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("hop_x", int'(frog_x), e.x);
               check("hop_y", int'(frog_y), e.y);
               check("hop_win", int'(level_win), int'(e.win));
            end
         end else if (level_win) begin
            checks++;
            errors++;
            $display("FAIL stray_win: got level_win=1 without hop, expected 0");
         end
      end
   end

   // Grid rules: priority up>down>left>right, illegal targets are dropped
   task automatic model_apply(input logic [3:0] m, output bit win);
      int nx, ny;
      exp_t e;
      nx = mx;
      ny = my;
      win = 1'b0;
      if (m[3])      ny -= GRID;
      else if (m[2]) ny += GRID;
      else if (m[1]) nx -= GRID;
      else if (m[0]) nx += GRID;
      if (m != 4'b0 && nx >= 0 && nx <= MAXX && ny >= 0 && ny <= MAXY) begin
         mx = nx;
         my = ny;
         win = (ny == 0);
         e.x = nx; e.y = ny; e.win = win;
         exp_q.push_back(e);
      end
   endtask

   task automatic frame(input bit col);
      @(negedge clk);
      frame_start = 1'b1;
      collision = col;
      @(negedge clk);
      frame_start = 1'b0;
      collision = 1'b0;
   endtask

   task automatic set_btn(input logic [3:0] m);
      {btn_up, btn_down, btn_left, btn_right} = m;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_btn(4'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mx = SX;
      my = SY;
   endtask

   task automatic check_pos(input string tag);
      check({tag, "_x"}, int'(frog_x), mx);
      check({tag, "_y"}, int'(frog_y), my);
   endtask

   task automatic press(input logic [3:0] m, input int nframes, input string tag);
      bit win;
      @(negedge clk);
      set_btn(m);
      repeat (10) @(negedge clk);
      model_apply(m, win);
      repeat (nframes) frame(1'b0);
      set_btn(4'b0);
      repeat (10) @(negedge clk);
      if (win) begin
         frame(1'b0);
         mx = SX;
         my = SY;
      end
      check_pos(tag);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_x", int'(frog_x), SX);
      check("rst_y", int'(frog_y), SY);
      check("rst_dead", int'(frog_dead), 0);
      check("rst_hop", int'(hop), 0);
      check("rst_win", int'(level_win), 0);
      rst_n = 1'b1;

      // Short bounce: no event
      @(negedge clk);
      btn_right = 1'b1;
      repeat (3) @(negedge clk);
      btn_right = 1'b0;
      repeat (10) @(negedge clk);
      frame(1'b0);
      check_pos("glitch");

      press(4'b0001, 1, "right");
      press(4'b1000, 5, "hold_up");
      press(4'b1000, 1, "up_again");
      check("up_again_abs", int'(frog_y), 384);

      for (int i = 0; i < 12; i++) press(4'b0010, 1, "left_walk");
      check("left_bound_abs", int'(frog_x), 0);
      for (int i = 0; i < 3; i++) press(4'b0100, 1, "down_walk");
      check("down_bound_abs", int'(frog_y), 448);

      do_reset();
      press(4'b1010, 1, "up_left");
      check("up_left_x_abs", int'(frog_x), 320);
      check("up_left_y_abs", int'(frog_y), 416);
      for (int i = 0; i < 13; i++) press(4'b1000, 1, "goal_climb");

      // Collision wins over a pending hop
      press(4'b0001, 1, "pre_death");
      @(negedge clk);
      set_btn(4'b0001);
      repeat (10) @(negedge clk);
      frame(1'b1);
      check("death_dead", int'(frog_dead), 1);
      check_pos("death_frozen");
      set_btn(4'b1000);
      repeat (10) @(negedge clk);
      frame(1'b0);
      set_btn(4'b0);
      repeat (10) @(negedge clk);
      frame(1'b0);
      check("death_still", int'(frog_dead), 1);
      check_pos("death_still");
      frame(1'b0);
      mx = SX;
      my = SY;
      check("respawn_dead", int'(frog_dead), 0);
      check_pos("respawn");

      // Reset during death
      press(4'b0010, 1, "pre_death2");
      frame(1'b1);
      check("death2_dead", int'(frog_dead), 1);
      frame(1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_dead", int'(frog_dead), 0);
      check("mid_rst_x", int'(frog_x), SX);
      check("mid_rst_y", int'(frog_y), SY);
      mx = SX;
      my = SY;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      press(4'b0001, 1, "after_rst");

      for (int i = 0; i < 40; i++) press(4'($urandom_range(1, 15)), 1, "rand");

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frog_mover.md
# frog_mover

Sequential position controller that produces the frog's top-left pixel coordinates consumed by the frog drawer. Four raw push-buttons are synchronised and debounced; each press becomes one grid hop, applied only at frame start so the drawn square never tears. It also handles screen bounds, death freeze/respawn on collision, and the goal row.

## Interface
- GRID_SIZE, 32: hop distance and frog size, in pixels
- H_ACTIVE, 640: visible width; legal x is 0..H_ACTIVE-GRID_SIZE
- V_ACTIVE, 480: visible height; legal y is 0..V_ACTIVE-GRID_SIZE
- START_X, 320: spawn x
- START_Y, 448: spawn y
- DEBOUNCE_CYCLES, 250000: stable cycles needed before a button change is accepted
- DEATH_FRAMES, 60: frames frozen after a collision
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous, active-low reset
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high
- frame_start  in  1  one-cycle pulse, once per frame at start of vertical blanking
- collision  in  1  level; frog overlaps a hazard
- frog_x  out  10  frog left edge, pixels
- frog_y  out  10  frog top edge, pixels
- frog_dead  out  1  high while frozen after a death
- hop  out  1  one-cycle pulse when a move is applied
- level_win  out  1  one-cycle pulse when the frog reaches y=0

## Operation
- Per button:
  - 2-FF synchroniser feeds a saturating counter.
  - The debounced level flips only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A press event is the rising edge of the debounced level.
- Simultaneous press events resolve by priority: up > down > left > right. Only one direction is latched.
- Moves:
  - up: y-GRID_SIZE
  - down: y+GRID_SIZE
  - left: x-GRID_SIZE
  - right: x+GRID_SIZE
  - Compute in 11 bits. A result outside the legal range is discarded: position is unchanged and no hop pulse is issued.
- FSM states: IDLE, PENDING, HOLD, WIN, DEAD.
  - IDLE: a press event latches the direction and moves to PENDING.
  - PENDING: at frame_start, apply the move (hop=1 if legal).
    - New y=0 goes to WIN.
    - Otherwise go to HOLD.
  - HOLD: wait until all four debounced levels are low, then go to IDLE. Presses are ignored here, so a held button gives exactly one hop.
  - WIN: level_win pulses on the cycle the move is applied. At the next frame_start, load START_X/START_Y and go to HOLD.
  - DEAD: frog_dead=1 and the position is frozen.
    - A frame counter increments on each frame_start.
    - On the DEATH_FRAMES-th frame_start, load the start position, clear frog_dead, and go to HOLD.
- Collision:
  - Sampled only on frame_start, in IDLE, PENDING or HOLD. A hit moves to DEAD.
  - Collision beats a pending hop in the same cycle: no move, no hop pulse.
  - Ignored in WIN and DEAD.

## Timing
- Reset values:
  - frog_x=START_X, frog_y=START_Y
  - frog_dead=0, hop=0, level_win=0
  - state IDLE, debounced levels 0, counters 0
- Press-event latency: 2 sync cycles plus DEBOUNCE_CYCLES from a stable raw edge.
- Move latency: frog_x/frog_y, hop and level_win update on the clock edge that samples frame_start high in PENDING, and are visible the next cycle. All outputs are registered.
- Position changes only on a frame_start cycle.
- frame_start arriving on the same cycle as a press event in IDLE: the hop waits for the following frame_start.
- A button bounce shorter than DEBOUNCE_CYCLES produces no event.
- Asynchronous reset mid-hop or mid-death discards the latched direction and death counter immediately.

## Test plan
- Debounce, with DEBOUNCE_CYCLES=4 in sim:
  - 3-cycle btn_right glitch -> no hop.
  - Stable press -> after next frame_start, frog_x=352, hop pulses exactly once.
- Hold btn_up across 5 frame_starts -> exactly one hop, frog_y=416. Release then press again -> frog_y=384.
- Left bound:
  - Step to frog_x=0, then press left -> frog_x stays 0, no hop pulse, state returns to IDLE after release.
  - Same at frog_y=448 with down.
- Simultaneous up+left press -> only up applied: frog_y=416, frog_x=320.
- Goal: from frog_y=32, press up -> frog_y=0 with level_win high for one cycle. Next frame_start -> position 320/448.
- Death, with DEATH_FRAMES=3:
  - Assert collision on a frame_start with a hop pending -> no move, frog_dead=1.
  - Button presses are ignored while dead.
  - On the 3rd frame_start -> frog_dead=0, position 320/448.
  - Mid-death rst_n low -> immediate reset values.
